mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage load/store and network-access unit, fed directly by the EX/MEM pipeline register; its load result feeds the MEM/WB register.
- Drives the data-memory request/busy interface and the neuron-network (NoC) send/receive handshakes.
- Performs store byte-lane steering, load sign/zero extension and misalignment detection.
- Raises MEM_STALL to freeze all upstream pipeline registers while an access is outstanding.

Parameters:
NET_TIMEOUT_CYCLES, 1024, network handshake timeout in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
MEM_ALU_OUT  in  32  effective address / network destination
MEM_REG_DATA2  in  32  integer store data
MEM_FREG_DATA2  in  32  float store data
MEM_DATA_MEM_WRITE_DATA_SELECT  in  1  store data source: 0 = REG_DATA2, 1 = FREG_DATA2
MEM_DATA_MEM_WRITE  in  3  [2] = store enable; [1:0]: 00 = sb, 01 = sh, 10 = sw
MEM_DATA_MEM_READ  in  4  [3] = load enable; [2:0]: 000 = lb, 001 = lh, 010 = lw, 100 = lbu, 101 = lhu
MEM_NET_WRITE  in  1  network send request
MEM_NET_READ  in  1  network receive request
DMEM_ADDR  out  32  word-aligned address ({ALU_OUT[31:2], 2'b00})
DMEM_WRITE_DATA  out  32  lane-steered store data
DMEM_BYTE_EN  out  4  store byte enables
DMEM_READ_REQ  out  1  read request
DMEM_WRITE_REQ  out  1  write request
DMEM_READ_DATA  in  32  read word
DMEM_BUSY  in  1  memory not ready
NET_OUT_ADDR  out  32  destination (= ALU_OUT)
NET_OUT_DATA  out  32  selected store data
NET_OUT_VALID  out  1  send valid
NET_OUT_READY  in  1  send accept
NET_IN_DATA  in  32  received word
NET_IN_VALID  in  1  receive valid
NET_IN_READY  out  1  receive ready
MEM_LOAD_DATA  out  32  registered load/receive result
MEM_STALL  out  1  freeze upstream registers
MEM_MISALIGN  out  1  misaligned access flag (combinational)

Behaviour:
- FSM states: IDLE, MEM_ACC, NET_TX, NET_RX, DONE. On reset: state IDLE, MEM_LOAD_DATA = 0, all requests/valid/ready = 0, MEM_STALL = 0.
- IDLE, memory op (load or store enable set), aligned → MEM_ACC. Memory op has priority when a memory op and a network op are asserted together; the network op is dropped.
- IDLE, NET_WRITE → NET_TX. IDLE, NET_READ → NET_RX; NET_WRITE wins if both are set.
- IDLE, misaligned op (lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] ≠ 0):
  - MEM_MISALIGN = 1.
  - No request issued, no stall.
  - MEM_LOAD_DATA is held unchanged.
  - State remains IDLE.
- MEM_ACC:
  - READ_REQ or WRITE_REQ is held with stable address, data and byte enables.
  - MEM_STALL = 1.
  - On the first cycle with DMEM_BUSY = 0, loads register the extended byte/half/word from lane ALU_OUT[1:0]; state → DONE.
- Store steering:
  - sb: data replicated to all 4 lanes, BYTE_EN = 1 << addr[1:0].
  - sh: data in both halves, BYTE_EN = 0011 or 1100 per addr[1].
  - sw: BYTE_EN = 1111.
  - Loads drive BYTE_EN = 0000.
- NET_TX: NET_OUT_VALID = 1, stall = 1. When NET_OUT_READY = 1 the transfer completes; state → DONE.
- NET_RX: NET_IN_READY = 1, stall = 1. When NET_IN_VALID = 1, MEM_LOAD_DATA ← NET_IN_DATA; state → DONE.
- DONE:
  - All requests low, MEM_STALL = 0; the EX/MEM register advances at this edge.
  - State → IDLE unconditionally, so the same instruction is never re-issued.
- MEM_STALL is combinational: 1 in MEM_ACC, NET_TX and NET_RX. It is also 1 in IDLE when a legal access is being launched.
- Latency: a non-access instruction has 0 stall cycles. A memory access with zero busy cycles or a network access with an immediate handshake has 1 stall cycle plus the DONE cycle. Each busy or wait cycle adds one stall cycle.
- RESET asserted mid-access: state returns to IDLE at that edge and the pending access is abandoned.

Optional Feature:
- Macro: MEM_NET_TIMEOUT_EN.
- When defined:
  - A 32-bit counter is cleared on entry to NET_TX/NET_RX and counts each waiting cycle.
  - When it reaches NET_TIMEOUT_CYCLES the FSM goes to DONE, MEM_LOAD_DATA ← 0, and output port NET_TIMEOUT (1 bit) pulses for one cycle.
- When undefined: no counter and no NET_TIMEOUT port; network handshakes wait indefinitely.

Test Plan:
- sw, ALU_OUT = 0x100, REG_DATA2 = 0xDEADBEEF, BUSY = 0 → WRITE_REQ for 1 cycle, ADDR = 0x100, BYTE_EN = 1111, STALL high for 1 cycle.
- lb, ALU_OUT = 0x103, READ_DATA = 0x80112233, BUSY high for 3 cycles → STALL for 4 cycles, LOAD_DATA = 0xFFFFFF80; the same case as lbu → 0x00000080.
- sh, ALU_OUT = 0x202, select = 1, FREG_DATA2 = 0x3F80ABCD → BYTE_EN = 1100, WRITE_DATA = 0xABCDABCD.
- lw, ALU_OUT = 0x101 → MISALIGN = 1, no READ_REQ, STALL = 0, LOAD_DATA unchanged.
- NET_READ with NET_IN_VALID asserted 5 cycles later carrying 0x0000002A → LOAD_DATA = 0x2A, STALL for 6 cycles. NET_WRITE with READY tied high → VALID for 1 cycle.
- RESET asserted while in MEM_ACC with BUSY = 1 → next cycle: READ_REQ = 0, STALL = 0, LOAD_DATA = 0. With MEM_NET_TIMEOUT_EN and NET_TIMEOUT_CYCLES = 8, a NET_READ with no VALID → NET_TIMEOUT pulse after 8 cycles, LOAD_DATA = 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage load/store and neuron-network access unit with byte-lane steering and upstream stall.
// Optional network handshake timeout: define MEM_NET_TIMEOUT_EN to add the counter and the NET_TIMEOUT port.
module mem_access_stage #(
  parameter int NET_TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  input  logic [31:0] MEM_FREG_DATA2,
  input  logic        MEM_DATA_MEM_WRITE_DATA_SELECT,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic        MEM_NET_WRITE,
  input  logic        MEM_NET_READ,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITE_DATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic        DMEM_READ_REQ,
  output logic        DMEM_WRITE_REQ,
  input  logic [31:0] DMEM_READ_DATA,
  input  logic        DMEM_BUSY,
  output logic [31:0] NET_OUT_ADDR,
  output logic [31:0] NET_OUT_DATA,
  output logic        NET_OUT_VALID,
  input  logic        NET_OUT_READY,
  input  logic [31:0] NET_IN_DATA,
  input  logic        NET_IN_VALID,
  output logic        NET_IN_READY,
  output logic [31:0] MEM_LOAD_DATA,
  output logic        MEM_STALL,
  output logic        MEM_MISALIGN
`ifdef MEM_NET_TIMEOUT_EN
  ,
  output logic        NET_TIMEOUT
`endif
);

  // Handshakes: a request/valid/ready stays high until its completion condition is sampled
  // (DMEM_BUSY low, NET_OUT_READY high or NET_IN_VALID high) at a rising CLK edge.
  typedef enum logic [2:0] {IDLE, MEM_ACC, NET_TX, NET_RX, DONE} state_t;

  state_t      state, state_d;
  logic [31:0] load_data_q, load_d;
  logic        load_we;

  logic        is_load, is_store, mem_op, misalign_raw, launch, timeout_hit;
  logic [1:0]  acc_size;
  logic [2:0]  load_fn;
  logic [31:0] store_data, steered_data, ext_data;
  logic [3:0]  store_be;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // A word with both enables set is treated as a load.
  assign is_load  = MEM_DATA_MEM_READ[3];
  assign is_store = MEM_DATA_MEM_WRITE[2] & ~is_load;
  assign mem_op   = is_load | is_store;
  assign load_fn  = MEM_DATA_MEM_READ[2:0];
  assign acc_size = is_load ? load_fn[1:0] : MEM_DATA_MEM_WRITE[1:0];

  always_comb begin
    misalign_raw = 1'b0;
    if (mem_op) begin
      if (acc_size == 2'b01)      misalign_raw = MEM_ALU_OUT[0];
      else if (acc_size == 2'b10) misalign_raw = (MEM_ALU_OUT[1:0] != 2'b00);
    end
  end

  assign store_data = MEM_DATA_MEM_WRITE_DATA_SELECT ? MEM_FREG_DATA2 : MEM_REG_DATA2;

  always_comb begin
    steered_data = store_data;
    store_be     = 4'b0000;
    case (MEM_DATA_MEM_WRITE[1:0])
      2'b00: begin
        steered_data = {4{store_data[7:0]}};
        store_be     = 4'b0001 << MEM_ALU_OUT[1:0];
      end
      2'b01: begin
        steered_data = {2{store_data[15:0]}};
        store_be     = MEM_ALU_OUT[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  always_comb begin
    lane_byte = DMEM_READ_DATA[7:0];
    case (MEM_ALU_OUT[1:0])
      2'b01:   lane_byte = DMEM_READ_DATA[15:8];
      2'b10:   lane_byte = DMEM_READ_DATA[23:16];
      2'b11:   lane_byte = DMEM_READ_DATA[31:24];
      default: lane_byte = DMEM_READ_DATA[7:0];
    endcase
    lane_half = MEM_ALU_OUT[1] ? DMEM_READ_DATA[31:16] : DMEM_READ_DATA[15:0];
    case (load_fn)
      3'b000:  ext_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  ext_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  ext_data = {24'h0, lane_byte};
      3'b101:  ext_data = {16'h0, lane_half};
      default: ext_data = DMEM_READ_DATA;
    endcase
  end

  // Memory ops win over network ops; a misaligned memory op launches nothing at all.
  assign launch = ~RESET & (mem_op ? ~misalign_raw : (MEM_NET_WRITE | MEM_NET_READ));

`ifdef MEM_NET_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_q;

  assign timeout_hit = ((state == NET_TX && !NET_OUT_READY) || (state == NET_RX && !NET_IN_VALID))
                       && (wait_cnt == 32'(NET_TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt  <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == NET_TX || state == NET_RX) wait_cnt <= wait_cnt + 32'h1;
      else                                    wait_cnt <= 32'h0;
    end
  end

  assign NET_TIMEOUT = timeout_q;
`else
  localparam int unused_net_timeout = NET_TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      load_data_q <= 32'h0;
    end else begin
      state <= state_d;
      if (load_we) load_data_q <= load_d;
    end
  end

  always_comb begin
    state_d = state;
    load_we = 1'b0;
    load_d  = ext_data;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (!misalign_raw) state_d = MEM_ACC;
        end else if (MEM_NET_WRITE) begin
          state_d = NET_TX;
        end else if (MEM_NET_READ) begin
          state_d = NET_RX;
        end
      end
      MEM_ACC: begin
        if (!DMEM_BUSY) begin
          state_d = DONE;
          load_we = is_load;
        end
      end
      NET_TX: begin
        if (NET_OUT_READY) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          load_we = 1'b1;
          load_d  = 32'h0;
        end
      end
      NET_RX: begin
        if (NET_IN_VALID) begin
          state_d = DONE;
          load_we = 1'b1;
          load_d  = NET_IN_DATA;
        end else if (timeout_hit) begin
          state_d = DONE;
          load_we = 1'b1;
          load_d  = 32'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address, data and enables come straight from the EX/MEM register, which the stall holds steady.
  assign DMEM_ADDR       = {MEM_ALU_OUT[31:2], 2'b00};
  assign DMEM_WRITE_DATA = steered_data;
  assign DMEM_BYTE_EN    = is_store ? store_be : 4'b0000;
  assign DMEM_READ_REQ   = (state == MEM_ACC) & is_load;
  assign DMEM_WRITE_REQ  = (state == MEM_ACC) & is_store;
  assign NET_OUT_ADDR    = MEM_ALU_OUT;
  assign NET_OUT_DATA    = store_data;
  assign NET_OUT_VALID   = (state == NET_TX);
  assign NET_IN_READY    = (state == NET_RX);
  assign MEM_LOAD_DATA   = load_data_q;
  assign MEM_STALL       = (state == MEM_ACC) | (state == NET_TX) | (state == NET_RX)
                         | ((state == IDLE) & launch);
  assign MEM_MISALIGN    = (state == IDLE) & misalign_raw;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops, responders for memory/network, negedge monitor.
module tb_mem_access_stage;

`ifdef MEM_NET_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 1024;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] MEM_ALU_OUT, MEM_REG_DATA2, MEM_FREG_DATA2;
  logic        MEM_DATA_MEM_WRITE_DATA_SELECT;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic        MEM_NET_WRITE, MEM_NET_READ;
  logic [31:0] DMEM_ADDR, DMEM_WRITE_DATA, DMEM_READ_DATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        DMEM_READ_REQ, DMEM_WRITE_REQ, DMEM_BUSY;
  logic [31:0] NET_OUT_ADDR, NET_OUT_DATA, NET_IN_DATA, MEM_LOAD_DATA;
  logic        NET_OUT_VALID, NET_OUT_READY, NET_IN_VALID, NET_IN_READY;
  logic        MEM_STALL, MEM_MISALIGN;
`ifdef MEM_NET_TIMEOUT_EN
  logic        NET_TIMEOUT;
`endif

  mem_access_stage #(.NET_TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_REG_DATA2(MEM_REG_DATA2), .MEM_FREG_DATA2(MEM_FREG_DATA2),
    .MEM_DATA_MEM_WRITE_DATA_SELECT(MEM_DATA_MEM_WRITE_DATA_SELECT),
    .MEM_DATA_MEM_WRITE(MEM_DATA_MEM_WRITE), .MEM_DATA_MEM_READ(MEM_DATA_MEM_READ),
    .MEM_NET_WRITE(MEM_NET_WRITE), .MEM_NET_READ(MEM_NET_READ),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WRITE_DATA(DMEM_WRITE_DATA), .DMEM_BYTE_EN(DMEM_BYTE_EN),
    .DMEM_READ_REQ(DMEM_READ_REQ), .DMEM_WRITE_REQ(DMEM_WRITE_REQ),
    .DMEM_READ_DATA(DMEM_READ_DATA), .DMEM_BUSY(DMEM_BUSY),
    .NET_OUT_ADDR(NET_OUT_ADDR), .NET_OUT_DATA(NET_OUT_DATA),
    .NET_OUT_VALID(NET_OUT_VALID), .NET_OUT_READY(NET_OUT_READY),
    .NET_IN_DATA(NET_IN_DATA), .NET_IN_VALID(NET_IN_VALID), .NET_IN_READY(NET_IN_READY),
    .MEM_LOAD_DATA(MEM_LOAD_DATA), .MEM_STALL(MEM_STALL), .MEM_MISALIGN(MEM_MISALIGN)
`ifdef MEM_NET_TIMEOUT_EN
    , .NET_TIMEOUT(NET_TIMEOUT)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int run    = 0;
  int to_pulses = 0;
  logic [67:0] exp_wr_q[$];    // {addr, write_data, byte_en}
  logic [35:0] exp_rd_q[$];    // {addr, byte_en}
  logic [63:0] exp_tx_q[$];    // {net addr, net data}
  logic [34:0] exp_mis_q[$];   // {read_req, write_req, stall, load_data}
  logic [39:0] exp_done_q[$];  // {load_data, stall cycles after the launch cycle}

  function automatic void check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got output event expected none", name);
  endfunction

  // ---------------- responders ----------------
  int          busy_left = 0;
  int          rx_wait = 0;
  int          tx_wait = 0;
  logic [31:0] rx_data = 32'h0;

  always @(posedge CLK) begin
    #1;
    if ((DMEM_READ_REQ || DMEM_WRITE_REQ) && busy_left > 0) begin
      DMEM_BUSY = 1'b1;
      busy_left--;
    end else begin
      DMEM_BUSY = 1'b0;
    end
    if (NET_IN_READY && rx_wait == 0) begin
      NET_IN_VALID = 1'b1;
      NET_IN_DATA  = rx_data;
    end else begin
      NET_IN_VALID = 1'b0;
      if (NET_IN_READY) rx_wait--;
    end
    if (NET_OUT_VALID && tx_wait == 0) begin
      NET_OUT_READY = 1'b1;
    end else begin
      NET_OUT_READY = 1'b0;
      if (NET_OUT_VALID) tx_wait--;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RESET) begin
      run = 0;
    end else begin
      if (DMEM_WRITE_REQ && !DMEM_BUSY) begin
        if (exp_wr_q.size() == 0) unexpected("dmem_write");
        else check("dmem_write", {4'h0, DMEM_ADDR, DMEM_WRITE_DATA, DMEM_BYTE_EN}, {4'h0, exp_wr_q.pop_front()});
      end
      if (DMEM_READ_REQ && !DMEM_BUSY) begin
        if (exp_rd_q.size() == 0) unexpected("dmem_read");
        else check("dmem_read", {36'h0, DMEM_ADDR, DMEM_BYTE_EN}, {36'h0, exp_rd_q.pop_front()});
      end
      if (NET_OUT_VALID && NET_OUT_READY) begin
        if (exp_tx_q.size() == 0) unexpected("net_send");
        else check("net_send", {8'h0, NET_OUT_ADDR, NET_OUT_DATA}, {8'h0, exp_tx_q.pop_front()});
      end
      if (MEM_MISALIGN) begin
        if (exp_mis_q.size() == 0) unexpected("misalign");
        else check("misalign", {37'h0, DMEM_READ_REQ, DMEM_WRITE_REQ, MEM_STALL, MEM_LOAD_DATA},
                   {37'h0, exp_mis_q.pop_front()});
      end
`ifdef MEM_NET_TIMEOUT_EN
      if (NET_TIMEOUT) to_pulses++;
`endif
      // The first stall cycle of a run is the IDLE launch cycle; the rest are the access cycles.
      if (MEM_STALL) begin
        run++;
      end else if (run > 0) begin
        if (exp_done_q.size() == 0) unexpected("done");
        else check("done_load_stall", {32'h0, MEM_LOAD_DATA, 8'(run - 1)}, {32'h0, exp_done_q.pop_front()});
        run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_ops();
    MEM_DATA_MEM_WRITE = 3'b000;
    MEM_DATA_MEM_READ  = 4'b0000;
    MEM_NET_WRITE      = 1'b0;
    MEM_NET_READ       = 1'b0;
    MEM_DATA_MEM_WRITE_DATA_SELECT = 1'b0;
  endtask

  // Hold the op until the pipeline would advance (STALL low before an edge), then retire it.
  task automatic wait_accept();
    int n = 0;
    @(negedge CLK);
    while (MEM_STALL && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got stall after %0d cycles expected release", n);
    end
    @(posedge CLK);
    #1;
    clear_ops();
  endtask

  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                          input logic sel, input int busy);
    MEM_ALU_OUT = addr;
    MEM_DATA_MEM_WRITE_DATA_SELECT = sel;
    MEM_REG_DATA2  = sel ? ~data : data;
    MEM_FREG_DATA2 = sel ? data : ~data;
    MEM_DATA_MEM_WRITE = {1'b1, size};
    busy_left = busy;
    wait_accept();
  endtask

  task automatic do_load(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] rdata,
                         input int busy);
    MEM_ALU_OUT = addr;
    DMEM_READ_DATA = rdata;
    MEM_DATA_MEM_READ = {1'b1, fn};
    busy_left = busy;
    wait_accept();
  endtask

  task automatic do_net(input logic w, input logic r, input logic [31:0] addr, input logic [31:0] data,
                        input int wait_cycles);
    MEM_ALU_OUT   = addr;
    MEM_REG_DATA2 = data;
    rx_data       = data;
    rx_wait       = wait_cycles;
    tx_wait       = wait_cycles;
    MEM_NET_WRITE = w;
    MEM_NET_READ  = r;
    wait_accept();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    clear_ops();
    MEM_ALU_OUT = 32'h0; MEM_REG_DATA2 = 32'h0; MEM_FREG_DATA2 = 32'h0;
    DMEM_READ_DATA = 32'h0; DMEM_BUSY = 1'b0;
    NET_OUT_READY = 1'b0; NET_IN_VALID = 1'b0; NET_IN_DATA = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_outputs", {63'h0, DMEM_READ_REQ, DMEM_WRITE_REQ, NET_OUT_VALID, NET_IN_READY, MEM_STALL,
                            MEM_MISALIGN, MEM_LOAD_DATA, 3'b000}, 72'h0);
    @(posedge CLK);
    #1;

    // sw 0x100, busy 0
    exp_wr_q.push_back({32'h0000_0100, 32'hDEAD_BEEF, 4'b1111});
    exp_done_q.push_back({32'h0, 8'd1});
    do_store(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0);

    // lb / lbu 0x103, busy 3 cycles
    exp_rd_q.push_back({32'h0000_0100, 4'b0000});
    exp_done_q.push_back({32'hFFFF_FF80, 8'd4});
    do_load(3'b000, 32'h0000_0103, 32'h8011_2233, 3);
    exp_rd_q.push_back({32'h0000_0100, 4'b0000});
    exp_done_q.push_back({32'h0000_0080, 8'd4});
    do_load(3'b100, 32'h0000_0103, 32'h8011_2233, 3);

    // sh 0x202 from the float register
    exp_wr_q.push_back({32'h0000_0200, 32'hABCD_ABCD, 4'b1100});
    exp_done_q.push_back({32'h0000_0080, 8'd1});
    do_store(2'b01, 32'h0000_0202, 32'h3F80_ABCD, 1'b1, 0);

    // sb 0x101, busy 1
    exp_wr_q.push_back({32'h0000_0100, 32'h7878_7878, 4'b0010});
    exp_done_q.push_back({32'h0000_0080, 8'd2});
    do_store(2'b00, 32'h0000_0101, 32'h1234_5678, 1'b0, 1);

    // lh upper half, lhu upper half
    exp_rd_q.push_back({32'h0000_0100, 4'b0000});
    exp_done_q.push_back({32'hFFFF_8011, 8'd1});
    do_load(3'b001, 32'h0000_0102, 32'h8011_2233, 0);
    exp_rd_q.push_back({32'h0000_0104, 4'b0000});
    exp_done_q.push_back({32'h0000_CAFE, 8'd1});
    do_load(3'b101, 32'h0000_0106, 32'hCAFE_F00D, 0);

    // misaligned lw and sh: flag only, load data held
    exp_mis_q.push_back({3'b000, 32'h0000_CAFE});
    do_load(3'b010, 32'h0000_0101, 32'h1111_1111, 0);
    exp_mis_q.push_back({3'b000, 32'h0000_CAFE});
    do_store(2'b01, 32'h0000_0203, 32'h2222_2222, 1'b0, 0);

    // aligned lw
    exp_rd_q.push_back({32'h0000_0108, 4'b0000});
    exp_done_q.push_back({32'h0102_0304, 8'd1});
    do_load(3'b010, 32'h0000_0108, 32'h0102_0304, 0);

    // network receive, valid after 5 wait cycles
    exp_done_q.push_back({32'h0000_002A, 8'd6});
    do_net(1'b0, 1'b1, 32'h0000_0033, 32'h0000_002A, 5);

    // network send, ready immediately
    exp_tx_q.push_back({32'h0000_0055, 32'h1122_3344});
    exp_done_q.push_back({32'h0000_002A, 8'd1});
    do_net(1'b1, 1'b0, 32'h0000_0055, 32'h1122_3344, 0);

    // store together with network send: the network op is dropped
    exp_wr_q.push_back({32'h0000_010C, 32'hCAFE_BABE, 4'b1111});
    exp_done_q.push_back({32'h0000_002A, 8'd1});
    MEM_NET_WRITE = 1'b1;
    tx_wait = 0;
    do_store(2'b10, 32'h0000_010C, 32'hCAFE_BABE, 1'b0, 0);

    // send and receive together: send wins, ready after 2 wait cycles
    exp_tx_q.push_back({32'h0000_0077, 32'h0BAD_F00D});
    exp_done_q.push_back({32'h0000_002A, 8'd3});
    do_net(1'b1, 1'b1, 32'h0000_0077, 32'h0BAD_F00D, 2);

`ifdef MEM_NET_TIMEOUT_EN
    // receive that never gets valid: times out after 8 waiting cycles, load data cleared
    exp_done_q.push_back({32'h0, 8'd8});
    do_net(1'b0, 1'b1, 32'h0000_0099, 32'h5555_5555, 1000);
    rx_wait = 0;
    repeat (2) @(negedge CLK);
    check("timeout_pulses", 72'(to_pulses), 72'd1);
    @(posedge CLK);
    #1;
    // give load data a non-zero value so the reset check below means something
    exp_rd_q.push_back({32'h0000_0110, 4'b0000});
    exp_done_q.push_back({32'h0000_0077, 8'd1});
    do_load(3'b010, 32'h0000_0110, 32'h0000_0077, 0);
`endif

    // reset in the middle of a busy load
    MEM_ALU_OUT = 32'h0000_0300;
    DMEM_READ_DATA = 32'h1234_5678;
    MEM_DATA_MEM_READ = 4'b1010;
    busy_left = 100;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    clear_ops();
    busy_left = 0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_mid_access", {38'h0, DMEM_READ_REQ, MEM_STALL, MEM_LOAD_DATA}, 72'h0);

    repeat (4) @(negedge CLK);
    check("wr_q_drained", 72'(exp_wr_q.size()), 72'd0);
    check("rd_q_drained", 72'(exp_rd_q.size()), 72'd0);
    check("tx_q_drained", 72'(exp_tx_q.size()), 72'd0);
    check("mis_q_drained", 72'(exp_mis_q.size()), 72'd0);
    check("done_q_drained", 72'(exp_done_q.size()), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
